microwave_controller: RTL and testbench
=======================================

# microwave_controller

Sequencing FSM for the microwave's MM:SS countdown timer datapath. Converts keypad digits into timer load pulses, gates the 1 Hz countdown enable from a clock prescaler, and drives the magnetron and end-of-cook beeper. Handles door interlock, start, and stop/clear. Sits between the front-panel inputs and the three-digit timer, which it drives through `timer_load`, `timer_en`, `timer_clear` and `timer_digit`.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clock cycles per countdown tick (1 s at 50 MHz); must be ≥ 2.
- `BEEP_CYCLES`, default 100_000_000: beeper duration in the DONE state; used only with the beep feature.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `keypad_valid`  in  1  digit strobe, level; only its rising edge is used.
- `keypad_digit`  in  4  BCD digit, sampled on the rising edge of `keypad_valid`.
- `start`  in  1  start/resume request, level.
- `stop_clear`  in  1  stop/clear request, level.
- `door_closed`  in  1  1 = door closed; magnetron interlock.
- `timer_zero`  in  1  timer reports 0:00.
- `timer_load`  out  1  one-cycle pulse; timer shifts `timer_digit` in.
- `timer_digit`  out  4  registered digit presented with `timer_load`.
- `timer_en`  out  1  one-cycle countdown pulse.
- `timer_clear`  out  1  one-cycle synchronous clear pulse to the timer.
- `mag_on`  out  1  magnetron drive.
- `beep`  out  1  done indicator.

## Operation
- States: IDLE, ENTRY, COOK, PAUSE, DONE. On reset: IDLE, all outputs 0, prescaler 0, digit count 0, keypad edge register 0.
- Priority inside any state, highest first: `stop_clear`, door open, `start`, keypad.
- IDLE:
  - Rising edge of `keypad_valid` with digit ≤ 9: `timer_load` pulse, digit count = 1, go to ENTRY.
  - Digits 10–15 are ignored.
  - `start` is ignored.
- ENTRY:
  - Valid digit with count < 3: load pulse, count+1. A fourth digit is ignored.
  - `start` & `door_closed` & !`timer_zero`: clear prescaler, go to COOK.
  - `start` with the door open or with `timer_zero` = 1: ignored.
  - `stop_clear`: `timer_clear` pulse, count = 0, go to IDLE.
- COOK:
  - `mag_on` = 1. Prescaler counts 0..TICK_DIV-1 and wraps; each wrap issues one `timer_en` pulse.
  - `door_closed` = 0 or `stop_clear`: go to PAUSE with the prescaler frozen.
  - `timer_zero` = 1: go to DONE. A stop/door event in the same cycle takes precedence and goes to PAUSE.
  - Keypad is ignored.
- PAUSE:
  - `mag_on` = 0; prescaler holds its value.
  - `start` & `door_closed`: go to COOK and resume from the held prescaler value.
  - `stop_clear`, held on a cycle sampled in PAUSE: `timer_clear` pulse, go to IDLE. A single press therefore pauses; a second press, or holding it, clears.
  - `start` and `stop_clear` both asserted: clear wins.
- DONE: described under Configuration. On exit to IDLE: `timer_clear` pulse, count = 0.

## Timing
- All outputs are registered and change one cycle after the sampled cause.
- `timer_load`, `timer_en` and `timer_clear` are exactly one cycle wide. `timer_digit` is valid in the same cycle as `timer_load` and holds its value afterwards.
- `mag_on` rises in the cycle after the COOK transition. It falls in the cycle after the PAUSE or DONE transition, within one cycle of the door opening.
- First `timer_en` comes TICK_DIV cycles after COOK entry from ENTRY.
- `timer_en` and `timer_load` are never asserted together. `timer_clear` suppresses both in its cycle.
- `clear` asserted mid-cook: `mag_on` = 0 immediately (asynchronous).

## Configuration
- `MICROWAVE_DONE_BEEP_EN` defined:
  - DONE asserts `beep` for BEEP_CYCLES cycles, then goes to IDLE.
  - `start` or `stop_clear` during DONE goes to IDLE immediately.
- Not defined:
  - DONE lasts one cycle, then goes to IDLE.
  - `beep` is tied to 0; the beep counter is not built.

## Structure
- Package `microwave_pkg`:
  - state enum `mw_state_t`
  - constants `DIGITS_MAX` = 3 and `BCD_MAX` = 9
- Sub-module `tick_prescaler`:
  - inputs: `clk`, `clear`, `run`, `restart`
  - output: one-cycle `tick`
  - width $clog2(TICK_DIV)
- FSM, keypad edge detect and digit counter live in `microwave_controller`.

## Test plan
All scenarios use TICK_DIV = 4 and BEEP_CYCLES = 3.
- Reset, then key digits 1, 3, 0, 7 → exactly three `timer_load` pulses with digits 1, 3, 0; the 7 is dropped; state is ENTRY.
- Digits 2, 5, then `start` with door closed → `mag_on` = 1 next cycle; `timer_en` pulses every 4 cycles; first pulse 4 cycles after COOK entry.
- During COOK, open the door 2 cycles after a tick → `mag_on` drops next cycle. Close the door and assert `start` → next `timer_en` comes 2 cycles after resume.
- `timer_zero` in COOK, macro defined → `mag_on` = 0, `beep` high for 3 cycles, then one `timer_clear` pulse and IDLE. Macro undefined → `beep` stays 0.
- `start` with the door open, or with `timer_zero` = 1, in ENTRY → no state change, `mag_on` stays 0.
- `stop_clear` held from COOK → PAUSE, then `timer_clear` pulse on the next cycle, then IDLE. Async `clear` during COOK → all outputs 0 immediately.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave front-panel sequencer.
// The optional end-of-cook beeper is enabled with MICROWAVE_DONE_BEEP_EN.
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } mw_state_t;

  // Number of MM:SS digits the timer accepts (M:SS, three digits)
  localparam logic [1:0] DIGITS_MAX = 2'd3;
  // Largest legal BCD keypad digit
  localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/microwave_controller_tick_prescaler.sv
// Countdown prescaler: divides clk by TICK_DIV while running, holds its
// count while paused, and returns to zero on restart.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic clear,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Tick fires on the cycle the counter wraps; consumer registers it
  assign tick = run && !restart && (cnt == LAST);

  // Prescaler count: restart wins, otherwise advance only while running
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (run) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/microwave_controller.sv
// Microwave front-panel sequencer: keypad entry, start/pause/clear, door
// interlock, 1 Hz countdown gating and magnetron/beeper drive.
// Optional feature macro: MICROWAVE_DONE_BEEP_EN (timed end-of-cook beep).
module microwave_controller
  import microwave_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int BEEP_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       keypad_valid,
  input  logic [3:0] keypad_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic       timer_load,
  output logic [3:0] timer_digit,
  output logic       timer_en,
  output logic       timer_clear,
  output logic       mag_on,
  output logic       beep
);

  // Elaboration-time sanity check of the configuration
  if (TICK_DIV < 2 || BEEP_CYCLES < 1) begin : g_bad_params
    $error("microwave_controller: TICK_DIV must be >= 2 and BEEP_CYCLES >= 1");
  end

  mw_state_t  state;
  logic       key_q;
  logic [1:0] count;

  logic key_rise;
  logic key_ok;
  logic run;
  logic restart;
  logic tick;
  logic done_exit;

  assign key_rise = keypad_valid & ~key_q;
  assign key_ok   = key_rise && (keypad_digit <= BCD_MAX);

  // Prescaler advances only on a cycle where COOK will stay in COOK, so a
  // pause or finish freezes it exactly at the value it had when sampled.
  assign run     = (state == COOK) && door_closed && !stop_clear && !timer_zero;
  assign restart = (state != COOK) && (state != PAUSE);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .clear   (clear),
    .run     (run),
    .restart (restart),
    .tick    (tick)
  );

`ifdef MICROWAVE_DONE_BEEP_EN
  localparam int BW = $clog2(BEEP_CYCLES + 1);
  logic [BW-1:0] beep_cnt;

  assign done_exit = start || stop_clear || (beep_cnt == BW'(BEEP_CYCLES - 1));
`else
  assign done_exit = 1'b1;
  assign beep      = 1'b0;
`endif

  // Main sequencer: state, keypad edge register, digit count and all outputs
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      key_q       <= 1'b0;
      count       <= 2'd0;
      timer_load  <= 1'b0;
      timer_digit <= 4'd0;
      timer_en    <= 1'b0;
      timer_clear <= 1'b0;
      mag_on      <= 1'b0;
`ifdef MICROWAVE_DONE_BEEP_EN
      beep        <= 1'b0;
      beep_cnt    <= '0;
`endif
    end else begin
      key_q       <= keypad_valid;
      timer_load  <= 1'b0;
      timer_en    <= 1'b0;
      timer_clear <= 1'b0;

      case (state)
        IDLE: begin
          mag_on <= 1'b0;
          if (!stop_clear && key_ok) begin
            timer_load  <= 1'b1;
            timer_digit <= keypad_digit;
            count       <= 2'd1;
            state       <= ENTRY;
          end
        end

        ENTRY: begin
          if (stop_clear) begin
            timer_clear <= 1'b1;
            count       <= 2'd0;
            state       <= IDLE;
          end else if (start && door_closed && !timer_zero) begin
            mag_on <= 1'b1;
            state  <= COOK;
          end else if (key_ok && (count < DIGITS_MAX)) begin
            timer_load  <= 1'b1;
            timer_digit <= keypad_digit;
            count       <= count + 2'd1;
          end
        end

        COOK: begin
          if (stop_clear || !door_closed) begin
            mag_on <= 1'b0;
            state  <= PAUSE;
          end else if (timer_zero) begin
            mag_on <= 1'b0;
            state  <= DONE;
`ifdef MICROWAVE_DONE_BEEP_EN
            beep     <= 1'b1;
            beep_cnt <= '0;
`endif
          end else begin
            mag_on   <= 1'b1;
            timer_en <= tick;
          end
        end

        PAUSE: begin
          if (stop_clear) begin
            timer_clear <= 1'b1;
            count       <= 2'd0;
            state       <= IDLE;
          end else if (start && door_closed) begin
            mag_on <= 1'b1;
            state  <= COOK;
          end
        end

        DONE: begin
          mag_on <= 1'b0;
          if (done_exit) begin
            timer_clear <= 1'b1;
            count       <= 2'd0;
            state       <= IDLE;
`ifdef MICROWAVE_DONE_BEEP_EN
            beep        <= 1'b0;
          end else begin
            beep_cnt    <= beep_cnt + BW'(1);
`endif
          end
        end

        default: begin
          mag_on <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microwave_controller.sv
// Directed bench for microwave_controller with TICK_DIV = 4, BEEP_CYCLES = 3.
module tb_microwave_controller;
  import microwave_pkg::*;

  logic       clk;
  logic       clear;
  logic       keypad_valid;
  logic [3:0] keypad_digit;
  logic       start;
  logic       stop_clear;
  logic       door_closed;
  logic       timer_zero;
  logic       timer_load;
  logic [3:0] timer_digit;
  logic       timer_en;
  logic       timer_clear;
  logic       mag_on;
  logic       beep;

  int errors = 0;
  int checks = 0;

  microwave_controller #(
    .TICK_DIV    (4),
    .BEEP_CYCLES (3)
  ) dut (
    .clk          (clk),
    .clear        (clear),
    .keypad_valid (keypad_valid),
    .keypad_digit (keypad_digit),
    .start        (start),
    .stop_clear   (stop_clear),
    .door_closed  (door_closed),
    .timer_zero   (timer_zero),
    .timer_load   (timer_load),
    .timer_digit  (timer_digit),
    .timer_en     (timer_en),
    .timer_clear  (timer_clear),
    .mag_on       (mag_on),
    .beep         (beep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Strobe one keypad digit, check the load response, then release the strobe
  task automatic press(input logic [3:0] d, input logic exp_load, input logic [3:0] exp_digit,
                       input string tag);
    keypad_digit = d;
    keypad_valid = 1'b1;
    cyc();
    check({tag, "_load"}, 32'(timer_load), 32'(exp_load));
    check({tag, "_digit"}, 32'(timer_digit), 32'(exp_digit));
    keypad_valid = 1'b0;
    cyc();
    check({tag, "_load_off"}, 32'(timer_load), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear        = 1'b1;
    keypad_valid = 1'b0;
    keypad_digit = 4'd0;
    start        = 1'b0;
    stop_clear   = 1'b0;
    door_closed  = 1'b1;
    timer_zero   = 1'b0;
    cyc();
    cyc();

    // Reset state
    check("rst_load",  32'(timer_load),  32'd0);
    check("rst_digit", 32'(timer_digit), 32'd0);
    check("rst_en",    32'(timer_en),    32'd0);
    check("rst_clr",   32'(timer_clear), 32'd0);
    check("rst_mag",   32'(mag_on),      32'd0);
    check("rst_beep",  32'(beep),        32'd0);
    check("rst_state", 32'(dut.state),   32'(IDLE));
    clear = 1'b0;
    cyc();
    check("idle_state", 32'(dut.state), 32'(IDLE));

    // Digits 1,3,0 load; fourth digit 7 dropped
    press(4'd1, 1'b1, 4'd1, "d1");
    check("d1_state", 32'(dut.state), 32'(ENTRY));
    press(4'd3, 1'b1, 4'd3, "d3");
    press(4'd0, 1'b1, 4'd0, "d0");
    press(4'd7, 1'b0, 4'd0, "d7_drop");
    check("entry_state", 32'(dut.state), 32'(ENTRY));
    check("entry_count", 32'(dut.count), 32'd3);

    // Start with door open, then with timer_zero: both ignored
    door_closed = 1'b0;
    start       = 1'b1;
    cyc();
    check("start_door_open_state", 32'(dut.state), 32'(ENTRY));
    check("start_door_open_mag",   32'(mag_on),    32'd0);
    door_closed = 1'b1;
    timer_zero  = 1'b1;
    cyc();
    check("start_zero_state", 32'(dut.state), 32'(ENTRY));
    check("start_zero_mag",   32'(mag_on),    32'd0);
    start      = 1'b0;
    timer_zero = 1'b0;

    // stop_clear in ENTRY clears and returns to IDLE
    stop_clear = 1'b1;
    cyc();
    check("entry_clr_pulse", 32'(timer_clear), 32'd1);
    check("entry_clr_state", 32'(dut.state),   32'(IDLE));
    stop_clear = 1'b0;
    cyc();
    check("entry_clr_off", 32'(timer_clear), 32'd0);

    // Non-BCD digit in IDLE ignored
    press(4'd12, 1'b0, 4'd0, "d12");
    check("d12_state", 32'(dut.state), 32'(IDLE));

    // Digits 2,5 then start: cook with a tick every 4 cycles
    press(4'd2, 1'b1, 4'd2, "d2");
    press(4'd5, 1'b1, 4'd5, "d5");
    start = 1'b1;
    cyc();
    check("cook_mag",   32'(mag_on),    32'd1);
    check("cook_state", 32'(dut.state), 32'(COOK));
    check("cook_en0",   32'(timer_en),  32'd0);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check($sformatf("cook_en_c%0d", k), 32'(timer_en), ((k % 4) == 0) ? 32'd1 : 32'd0);
    end

    // Door opens two cycles after the tick: pause with prescaler held at 2
    cyc();
    check("cook_en_c9", 32'(timer_en), 32'd0);
    cyc();
    check("cook_en_c10", 32'(timer_en), 32'd0);
    door_closed = 1'b0;
    cyc();
    check("pause_mag",   32'(mag_on),    32'd0);
    check("pause_state", 32'(dut.state), 32'(PAUSE));
    cyc();
    check("pause_en_a", 32'(timer_en), 32'd0);
    cyc();
    check("pause_en_b", 32'(timer_en), 32'd0);
    door_closed = 1'b1;
    start       = 1'b1;
    cyc();
    check("resume_mag",   32'(mag_on),    32'd1);
    check("resume_state", 32'(dut.state), 32'(COOK));
    check("resume_en0",   32'(timer_en),  32'd0);
    start = 1'b0;
    cyc();
    check("resume_en1", 32'(timer_en), 32'd0);
    cyc();
    check("resume_en2", 32'(timer_en), 32'd1);

    // timer_zero ends the cook
    timer_zero = 1'b1;
    cyc();
    check("done_state", 32'(dut.state), 32'(DONE));
    check("done_mag",   32'(mag_on),    32'd0);
    check("done_en",    32'(timer_en),  32'd0);
`ifdef MICROWAVE_DONE_BEEP_EN
    check("beep_c0", 32'(beep), 32'd1);
    cyc();
    check("beep_c1",     32'(beep),        32'd1);
    check("beep_c1_clr", 32'(timer_clear), 32'd0);
    cyc();
    check("beep_c2", 32'(beep), 32'd1);
    cyc();
    check("beep_end",       32'(beep),        32'd0);
    check("beep_end_clr",   32'(timer_clear), 32'd1);
    check("beep_end_state", 32'(dut.state),   32'(IDLE));
    cyc();
    check("beep_clr_off", 32'(timer_clear), 32'd0);
`else
    check("nobeep_c0", 32'(beep), 32'd0);
    cyc();
    check("done_exit_clr",   32'(timer_clear), 32'd1);
    check("done_exit_state", 32'(dut.state),   32'(IDLE));
    check("nobeep_c1",       32'(beep),        32'd0);
    cyc();
    check("done_clr_off", 32'(timer_clear), 32'd0);
    check("nobeep_c2",    32'(beep),        32'd0);
`endif
    timer_zero = 1'b0;

    // stop_clear held from COOK: pause, then clear on the next cycle
    press(4'd4, 1'b1, 4'd4, "d4");
    start = 1'b1;
    cyc();
    check("cook2_mag", 32'(mag_on), 32'd1);
    start = 1'b0;
    cyc();
    stop_clear = 1'b1;
    cyc();
    check("stop_pause_state", 32'(dut.state),   32'(PAUSE));
    check("stop_pause_mag",   32'(mag_on),      32'd0);
    check("stop_pause_clr",   32'(timer_clear), 32'd0);
    cyc();
    check("stop_clr_pulse", 32'(timer_clear), 32'd1);
    check("stop_clr_state", 32'(dut.state),   32'(IDLE));
    stop_clear = 1'b0;
    cyc();
    check("stop_clr_off", 32'(timer_clear), 32'd0);

    // Asynchronous clear mid-cook
    press(4'd9, 1'b1, 4'd9, "d9");
    start = 1'b1;
    cyc();
    check("cook3_mag", 32'(mag_on), 32'd1);
    start = 1'b0;
    cyc();
    clear = 1'b1;
    #1;
    check("async_mag",   32'(mag_on),      32'd0);
    check("async_state", 32'(dut.state),   32'(IDLE));
    check("async_digit", 32'(timer_digit), 32'd0);
    check("async_en",    32'(timer_en),    32'd0);
    cyc();
    clear = 1'b0;
    cyc();
    check("post_async_mag", 32'(mag_on), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
